// File: rtl/btb_pkg.sv
// Shared definitions for the BTB pseudo-LRU replacement unit: default
// geometry, derived widths, the per-set state record and the flush FSM states.
package btb_pkg;

  localparam int BTB_NUM_SETS = 8;
  localparam int BTB_NUM_WAYS = 4;

  localparam int BTB_IDX_W  = $clog2(BTB_NUM_SETS);
  localparam int BTB_WAY_W  = $clog2(BTB_NUM_WAYS);
  localparam int BTB_TREE_W = BTB_NUM_WAYS - 1;

  // One set's replacement state: heap-ordered tree bits plus per-way valid.
  typedef struct packed {
    logic [BTB_TREE_W-1:0]   tree;
    logic [BTB_NUM_WAYS-1:0] valid;
  } plru_set_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } flush_state_e;

endpackage

// File: rtl/btb_plru_tree.sv
// Combinational tree-PLRU logic for a single set.
// Produces the victim way for the current state and the tree bits that result
// from an access to access_way, together with a mask of the nodes on that path.
// Optional feature: BTB_PLRU_VALID_EN makes the lowest invalid way win over the
// tree walk.
module plru_tree
  import btb_pkg::*;
#(
  parameter int NUM_WAYS = BTB_NUM_WAYS
) (
  input  logic [NUM_WAYS-2:0]         tree,
  input  logic [NUM_WAYS-1:0]         valid,
  input  logic [$clog2(NUM_WAYS)-1:0] access_way,
  output logic [$clog2(NUM_WAYS)-1:0] victim,
  output logic [NUM_WAYS-2:0]         tree_next,
  output logic [NUM_WAYS-2:0]         path_mask
);

  localparam int LVL   = $clog2(NUM_WAYS);
  localparam int WAY_W = LVL;

  logic [WAY_W-1:0] tree_victim;

  // Walk from the root following the node bits; each bit chosen is one way bit.
  always_comb begin
    int unsigned node;
    int unsigned way;
    node = 0;
    way  = 0;
    for (int l = 0; l < LVL; l++) begin
      way  = (way << 1) | 32'(tree[node]);
      node = 2 * node + 1 + 32'(tree[node]);
    end
    tree_victim = WAY_W'(way);
  end

  // Point every node on the path to access_way away from it.
  always_comb begin
    int unsigned node;
    logic        b;
    tree_next = tree;
    path_mask = '0;
    node      = 0;
    b         = 1'b0;
    for (int l = 0; l < LVL; l++) begin
      b               = access_way[LVL-1-l];
      tree_next[node] = ~b;
      path_mask[node] = 1'b1;
      node            = 2 * node + 1 + 32'(b);
    end
  end

`ifdef BTB_PLRU_VALID_EN
  // Prefer the lowest-numbered invalid way; fall back to the tree walk.
  always_comb begin
    victim = tree_victim;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!valid[w]) victim = WAY_W'(w);
    end
  end
`else
  logic valid_unused;
  assign valid_unused = ^valid;
  assign victim       = tree_victim;
`endif

endmodule

// File: rtl/btb_plru.sv
// N-way tree pseudo-LRU replacement state for the BTB.
// Holds one tree (and optionally one valid vector) per set, merges same-cycle
// touch / update / invalidate events, and runs a one-set-per-cycle flush sweep.
// Optional feature: BTB_PLRU_VALID_EN keeps per-way valid bits, enables the
// invalid-way preference and makes the inv_* ports functional.
module btb_plru
  import btb_pkg::*;
#(
  parameter int NUM_SETS = BTB_NUM_SETS,
  parameter int NUM_WAYS = BTB_NUM_WAYS
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        touch_valid,
  input  logic [$clog2(NUM_SETS)-1:0] touch_index,
  input  logic [$clog2(NUM_WAYS)-1:0] touch_way,
  input  logic [$clog2(NUM_SETS)-1:0] upd_index,
  output logic [$clog2(NUM_WAYS)-1:0] victim_way,
  input  logic                        upd_valid,
  input  logic [$clog2(NUM_WAYS)-1:0] upd_way,
  input  logic                        inv_valid,
  input  logic [$clog2(NUM_SETS)-1:0] inv_index,
  input  logic [$clog2(NUM_WAYS)-1:0] inv_way,
  input  logic                        flush_req,
  output logic                        flush_busy
);

  localparam int IDX_W  = $clog2(NUM_SETS);
  localparam int WAY_W  = $clog2(NUM_WAYS);
  localparam int TREE_W = NUM_WAYS - 1;
  localparam logic [IDX_W-1:0] LAST_SET = IDX_W'(NUM_SETS - 1);

  logic [TREE_W-1:0] tree_q [NUM_SETS];
  flush_state_e      state_q;
  logic [IDX_W-1:0]  ptr_q;

  logic [NUM_WAYS-1:0] upd_set_valid;
  logic [TREE_W-1:0]   touch_next;
  logic [TREE_W-1:0]   touch_mask_unused;
  logic [WAY_W-1:0]    touch_victim_unused;
  logic [TREE_W-1:0]   upd_next;
  logic [TREE_W-1:0]   upd_mask;
  logic [TREE_W-1:0]   upd_base;
  logic [TREE_W-1:0]   upd_merged;
  logic                same_set;

`ifdef BTB_PLRU_VALID_EN
  logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
  assign upd_set_valid = valid_q[upd_index];
`else
  logic inv_unused;
  assign inv_unused    = ^{inv_valid, inv_index, inv_way};
  assign upd_set_valid = '1;
`endif

  plru_tree #(.NUM_WAYS(NUM_WAYS)) u_touch_tree (
    .tree       (tree_q[touch_index]),
    .valid      ('1),
    .access_way (touch_way),
    .victim     (touch_victim_unused),
    .tree_next  (touch_next),
    .path_mask  (touch_mask_unused)
  );

  // The update instance also supplies victim_way, since both look at upd_index.
  plru_tree #(.NUM_WAYS(NUM_WAYS)) u_upd_tree (
    .tree       (tree_q[upd_index]),
    .valid      (upd_set_valid),
    .access_way (upd_way),
    .victim     (victim_way),
    .tree_next  (upd_next),
    .path_mask  (upd_mask)
  );

  // When touch and update share a set, start from the touched tree so that
  // touch-only nodes survive and the update path overrides shared nodes.
  always_comb begin
    same_set   = touch_valid && (touch_index == upd_index);
    upd_base   = same_set ? touch_next : tree_q[upd_index];
    upd_merged = (upd_base & ~upd_mask) | (upd_next & upd_mask);
  end

  // Tree state: reset / sweep clear, otherwise touch then update (update last wins).
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NUM_SETS; s++) tree_q[s] <= '0;
    end else if (state_q == SWEEP) begin
      tree_q[ptr_q] <= '0;
    end else begin
      if (touch_valid) tree_q[touch_index] <= touch_next;
      if (upd_valid)   tree_q[upd_index]   <= upd_merged;
    end
  end

`ifdef BTB_PLRU_VALID_EN
  // Valid state: invalidate first so a same-entry insertion overrides it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NUM_SETS; s++) valid_q[s] <= '0;
    end else if (state_q == SWEEP) begin
      valid_q[ptr_q] <= '0;
    end else begin
      if (inv_valid) valid_q[inv_index][inv_way] <= 1'b0;
      if (upd_valid) valid_q[upd_index][upd_way] <= 1'b1;
    end
  end
`endif

  // Flush FSM: one set cleared per SWEEP cycle, busy flag registered alongside.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      flush_busy <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (flush_req) begin
            state_q    <= SWEEP;
            ptr_q      <= '0;
            flush_busy <= 1'b1;
          end
        end
        SWEEP: begin
          if (ptr_q == LAST_SET) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            flush_busy <= 1'b0;
          end else begin
            ptr_q <= ptr_q + IDX_W'(1);
          end
        end
        default: begin
          state_q    <= IDLE;
          ptr_q      <= '0;
          flush_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
